regfile_wb_arbiter: RTL

//  Shares the single register-file write port between two writeback requesters:
//  ALU results (alu_*) and load-unit results (ld_*). Uses valid/ready handshakes
//  and ALU-first priority, with an anti-starvation promotion for loads. Drives a

---
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Groups the writeback requester handshakes, the register-file
//               write port and the operand read/bypass signals.
//               The arbiter uses the slave modport. The pipeline side or the
//               bench uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] write_Rd;
  logic [DATA_W-1:0] write_data;
  logic              wb_commit;
  logic [ADDR_W-1:0] read_Ra;
  logic [ADDR_W-1:0] read_Rb;
  logic [DATA_W-1:0] rf_data_Ra;
  logic [DATA_W-1:0] rf_data_Rb;
  logic [DATA_W-1:0] data_Ra;
  logic [DATA_W-1:0] data_Rb;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  read_Ra, read_Rb, rf_data_Ra, rf_data_Rb,
    output alu_ready, ld_ready, write_Rd, write_data, wb_commit,
    output data_Ra, data_Rb
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output read_Ra, read_Rb, rf_data_Ra, rf_data_Rb,
    input  alu_ready, ld_ready, write_Rd, write_data, wb_commit,
    input  data_Ra, data_Rb
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates the single register-file write port between ALU and
//               load writeback. ALU has priority. A load that loses contention
//               MAX_WAIT times in a row is promoted. The write port is
//               registered and drives R0 (discard) when idle.
//               Optional macro REGFILE_BYPASS_EN forwards the committing write
//               onto the operand read paths.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ALU_PRI  = 1'b0,
    LOAD_PRI = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_next;
  logic                w_alu_grant;
  logic                w_ld_grant;
  logic [ADDR_W-1:0]   r_write_rd;
  logic [DATA_W-1:0]   r_write_data;
  logic                r_wb_commit;

  // Grant selection and starvation tracking; nothing is granted while in reset.
  always_comb begin
    w_alu_grant     = 1'b0;
    w_ld_grant      = 1'b0;
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    if (rst_n) begin
      if (bus.alu_valid && bus.ld_valid) begin
        if (r_state == LOAD_PRI) w_ld_grant  = 1'b1;
        else                     w_alu_grant = 1'b1;
      end else begin
        w_alu_grant = bus.alu_valid;
        w_ld_grant  = bus.ld_valid;
      end
    end
    if (w_ld_grant || !bus.ld_valid) begin
      w_wait_cnt_next = '0;
      if (w_ld_grant) w_state_next = ALU_PRI;
    end else if (bus.alu_valid) begin
      // Contended load loss: count it, promote once the limit is reached.
      w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
      if (r_state == ALU_PRI && r_wait_cnt == c_WAIT_LAST) w_state_next = LOAD_PRI;
    end
  end

  // Priority state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ALU_PRI;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Registered write port; R0 requests and idle cycles both become discard writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write_rd   <= '0;
      r_write_data <= '0;
      r_wb_commit  <= 1'b0;
    end else if (w_alu_grant && bus.alu_rd != '0) begin
      r_write_rd   <= bus.alu_rd;
      r_write_data <= bus.alu_data;
      r_wb_commit  <= 1'b1;
    end else if (w_ld_grant && bus.ld_rd != '0) begin
      r_write_rd   <= bus.ld_rd;
      r_write_data <= bus.ld_data;
      r_wb_commit  <= 1'b1;
    end else begin
      r_write_rd   <= '0;
      r_write_data <= '0;
      r_wb_commit  <= 1'b0;
    end
  end

  assign bus.alu_ready  = w_alu_grant;
  assign bus.ld_ready   = w_ld_grant;
  assign bus.write_Rd   = r_write_rd;
  assign bus.write_data = r_write_data;
  assign bus.wb_commit  = r_wb_commit;

`ifdef REGFILE_BYPASS_EN
  // wb_commit is never set for R0, so R0 is never forwarded.
  assign bus.data_Ra = (r_wb_commit && r_write_rd == bus.read_Ra) ? r_write_data : bus.rf_data_Ra;
  assign bus.data_Rb = (r_wb_commit && r_write_rd == bus.read_Rb) ? r_write_data : bus.rf_data_Rb;
`else
  // Read addresses only matter for forwarding.
  logic w_unused_read_addr;
  assign w_unused_read_addr = ^{bus.read_Ra, bus.read_Rb};
  assign bus.data_Ra = bus.rf_data_Ra;
  assign bus.data_Rb = bus.rf_data_Rb;
`endif

endmodule
`default_nettype wire
